// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- the canonical RISC-V no-op shown to decode when nothing real is present
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // FETCH: request outstanding; HOLD: response parked in skid; DRAIN: discard stale response
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer that parks a memory response while decode is stalled.
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            full,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc
);

    logic            full_q, full_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // clear wins over load so a redirect can never leave a stale entry behind
    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    // buffer registers with synchronous reset to empty
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full  = full_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word read at a time, and presents a
// registered instruction plus its PC to decode. Handles stalls and redirects.
// Handshake: imem_req is a level held (with imem_addr stable) until the single-cycle
// imem_valid pulse; decode accepts Instr on any edge where instr_valid=1 and stall=0.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(3));

    fetch_state_t    state_q, state_d, rst_state;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    // memory has seen a request that it has not answered yet
    logic            pending_q, pending_d;

    logic            skid_load, skid_unload, skid_clear, skid_full;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & WORD_MASK;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // next-state, PC and output-register logic; redirect overrides stall in every state
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_out_d      = pc_out_q;
        pending_d     = imem_req && !imem_valid;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;

        // a request already seen by memory before reset still returns: drain it
        if (((state_q == FETCH && pending_q) || state_q == DRAIN) && !imem_valid) begin
            rst_state = DRAIN;
        end else begin
            rst_state = FETCH;
        end

        if (redirect) begin
            pc_d          = redirect_pc_aligned;
            instr_d       = NOP_INSTR;
            instr_valid_d = 1'b0;
            skid_clear    = 1'b1;
            if ((state_q == FETCH || state_q == DRAIN) && !imem_valid) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_valid) begin
                        pc_d = pc_q + PC_STEP;
                        if (stall) begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            instr_d       = imem_rdata;
                            pc_out_d      = pc_q;
                            instr_valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (skid_full) begin
                            instr_d       = skid_instr;
                            pc_out_d      = skid_pc;
                            instr_valid_d = 1'b1;
                        end
                        skid_unload = 1'b1;
                        state_d     = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= rst_state;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            pc_out_q      <= RESET_PC;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
            pending_q     <= pending_d;
        end
    end

    assign imem_req    = (state_q == FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: instance 0 uses RESET_PC=0, instance 1 uses RESET_PC=FFFF_FFFC.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        stall[2];
  logic        redirect[2];
  logic [31:0] rpc[2];
  logic        mreq[2];
  logic [31:0] maddr_o[2];
  logic        mvalid[2];
  logic [31:0] mrdata[2];
  logic [31:0] instr[2];
  logic        ivalid[2];
  logic [31:0] pco[2];
  logic [31:0] pcp4[2];

  int          checks = 0;
  int          errors = 0;

  // memory model state
  int          lat[2];
  bit          busy[2];
  int          cnt[2];
  logic [31:0] m_addr[2];
  bit          rand_lat = 1'b0;
  logic [31:0] mem_xor = 32'h0;

  logic [31:0] exp_q[$];

  fetch_stage u_a (
    .clk(clk), .rst(rst[0]), .stall(stall[0]), .redirect(redirect[0]), .redirect_pc(rpc[0]),
    .imem_req(mreq[0]), .imem_addr(maddr_o[0]), .imem_valid(mvalid[0]), .imem_rdata(mrdata[0]),
    .Instr(instr[0]), .instr_valid(ivalid[0]), .pc_out(pco[0]), .pc_plus4(pcp4[0])
  );

  fetch_stage #(.RESET_PC(RPC_B)) u_b (
    .clk(clk), .rst(rst[1]), .stall(stall[1]), .redirect(redirect[1]), .redirect_pc(rpc[1]),
    .imem_req(mreq[1]), .imem_addr(maddr_o[1]), .imem_valid(mvalid[1]), .imem_rdata(mrdata[1]),
    .Instr(instr[1]), .instr_valid(ivalid[1]), .pc_out(pco[1]), .pc_plus4(pcp4[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_start(input int i);
    busy[i]   = 1'b1;
    m_addr[i] = maddr_o[i];
    cnt[i]    = rand_lat ? int'($urandom_range(1, 4)) : lat[i];
  endtask

  // Memory: a request seen in cycle c answers with a one-edge valid pulse after `lat` cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i]) begin
        mvalid[i] = 1'b0;
        if (mreq[i]) mem_start(i);
      end else if (busy[i]) begin
        if (mreq[i]) chk($sformatf("addr_stable%0d", i), maddr_o[i], m_addr[i]);
        cnt[i] = cnt[i] - 1;
        if (cnt[i] == 0) begin
          mvalid[i] = 1'b1;
          mrdata[i] = m_addr[i] ^ mem_xor;
          busy[i]   = 1'b0;
        end
      end else if (mreq[i]) begin
        mem_start(i);
      end
    end
  end

  // driver helpers
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int i, input int n);
    rst[i] = 1'b1;
    repeat (n) step();
    rst[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int max_cycles, input string name,
                            output logic [31:0] first_addr);
    bit got = 1'b0;
    bit seen = 1'b0;
    first_addr = 32'hDEAD_BEEF;
    for (int k = 0; k < max_cycles && !seen; k++) begin
      step();
      if (mreq[i] && !got) begin
        got = 1'b1;
        first_addr = maddr_o[i];
      end
      if (ivalid[i]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: instr_valid stayed 0 for %0d cycles", name, max_cycles);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] fa;
    bit          found;
    int          consumed;
    logic        s, r;
    logic [31:0] tgt;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; stall[i] = 1'b0; redirect[i] = 1'b0; rpc[i] = '0;
      mvalid[i] = 1'b0; mrdata[i] = '0; busy[i] = 1'b0; cnt[i] = 0; m_addr[i] = '0; lat[i] = 1;
    end

    //              stall req  addr          valid instr         pc
    vecs[0] = '{1'b0, 1'b1, 32'h0,  1'b0, NOP_INSTR, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h0,     32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h4,  1'b0, 32'h0,     32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h8,  1'b1, 32'h4,     32'h4};
    vecs[4] = '{1'b1, 1'b1, 32'h8,  1'b0, 32'h4,     32'h4};
    vecs[5] = '{1'b1, 1'b0, 32'hC,  1'b0, 32'h4,     32'h4};
    vecs[6] = '{1'b0, 1'b0, 32'hC,  1'b0, 32'h4,     32'h4};
    vecs[7] = '{1'b0, 1'b1, 32'hC,  1'b1, 32'h8,     32'h8};
    vecs[8] = '{1'b0, 1'b1, 32'hC,  1'b0, 32'h8,     32'h8};
    vecs[9] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC,     32'hC};

    // reset state of instance 0
    step(); step();
    chk("rst_req", 32'(mreq[0]), 32'h0);
    chk("rst_valid", 32'(ivalid[0]), 32'h0);
    chk("rst_instr", instr[0], NOP_INSTR);
    chk("rst_pc", pco[0], 32'h0);
    chk("rst_pc4", pcp4[0], 32'h4);
    rst[0] = 1'b0;

    // 1-cycle memory streaming, then a stall across the response for PC 8
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("vec%0d_req", i), 32'(mreq[0]), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_addr", i), maddr_o[0], vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(ivalid[0]), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_instr", i), instr[0], vecs[i].exp_instr);
      chk($sformatf("vec%0d_pc", i), pco[0], vecs[i].exp_pc);
      chk($sformatf("vec%0d_pc4", i), pcp4[0], vecs[i].exp_pc + 32'h4);
      stall[0] = vecs[i].stall;
    end

    // redirect to 0x100 while a 3-cycle read is in flight
    lat[0] = 3;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (busy[0] && cnt[0] >= 2) found = 1'b1;
    end
    chk("t3_found", 32'(found), 32'h1);
    redirect[0] = 1'b1; rpc[0] = 32'h100;
    step();
    redirect[0] = 1'b0;
    chk("t3_drain_req", 32'(mreq[0]), 32'h0);
    chk("t3_valid", 32'(ivalid[0]), 32'h0);
    chk("t3_nop", instr[0], NOP_INSTR);
    wait_valid(0, 30, "t3", fa);
    chk("t3_first_addr", fa, 32'h100);
    chk("t3_instr", instr[0], 32'h100);
    chk("t3_pc", pco[0], 32'h100);

    // redirect in the same cycle as the response for PC 4
    lat[0] = 1;
    do_reset(0, 6);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (busy[0] && cnt[0] == 1 && m_addr[0] == 32'h4) found = 1'b1;
    end
    chk("t4_found", 32'(found), 32'h1);
    redirect[0] = 1'b1; rpc[0] = 32'h200;
    step();
    redirect[0] = 1'b0;
    chk("t4_req", 32'(mreq[0]), 32'h1);
    chk("t4_addr", maddr_o[0], 32'h200);
    chk("t4_valid", 32'(ivalid[0]), 32'h0);
    chk("t4_nop", instr[0], NOP_INSTR);
    wait_valid(0, 20, "t4", fa);
    chk("t4_instr", instr[0], 32'h200);
    chk("t4_pc", pco[0], 32'h200);

    // misaligned redirect while stalled
    stall[0] = 1'b1; redirect[0] = 1'b1; rpc[0] = 32'h103;
    step();
    redirect[0] = 1'b0;
    chk("t5_valid", 32'(ivalid[0]), 32'h0);
    chk("t5_nop", instr[0], NOP_INSTR);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (mreq[0]) begin
        found = 1'b1;
        fa = maddr_o[0];
      end else begin
        step();
      end
    end
    chk("t5_found", 32'(found), 32'h1);
    chk("t5_addr", fa, 32'h100);
    stall[0] = 1'b0;
    wait_valid(0, 20, "t5", fa);
    chk("t5_instr", instr[0], 32'h100);

    // instance 1: PC wrap from FFFF_FFFC, then reset while a read is pending
    chk("b_rst_req", 32'(mreq[1]), 32'h0);
    chk("b_rst_pc", pco[1], RPC_B);
    chk("b_rst_pc4", pcp4[1], 32'h0);
    rst[1] = 1'b0;
    wait_valid(1, 20, "b_first", fa);
    chk("b_first_addr", fa, RPC_B);
    chk("b_first_instr", instr[1], RPC_B);
    chk("b_wrap_pc4", pcp4[1], 32'h0);
    chk("b_wrap_addr", maddr_o[1], 32'h0);
    wait_valid(1, 20, "b_second", fa);
    chk("b_second_instr", instr[1], 32'h0);
    chk("b_second_pc", pco[1], 32'h0);
    lat[1] = 3;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (busy[1] && cnt[1] >= 2) found = 1'b1;
    end
    chk("b_mid_found", 32'(found), 32'h1);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    chk("b_mid_drain_req", 32'(mreq[1]), 32'h0);
    chk("b_mid_valid", 32'(ivalid[1]), 32'h0);
    wait_valid(1, 30, "b_mid", fa);
    chk("b_mid_first_addr", fa, RPC_B);
    chk("b_mid_instr", instr[1], RPC_B);
    chk("b_mid_pc", pco[1], RPC_B);
    rst[1] = 1'b1;

    // randomized stall/redirect traffic against an in-order program model
    mem_xor  = 32'h5A5A_0000;
    rand_lat = 1'b1;
    do_reset(0, 6);
    exp_q.delete();
    exp_q.push_back(32'h0);
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 31) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      stall[0] = s; redirect[0] = r; rpc[0] = tgt;
      if (ivalid[0] && !s) begin
        chk("rand_pc", pco[0], exp_q[0]);
        chk("rand_instr", instr[0], exp_q[0] ^ mem_xor);
        chk("rand_pc4", pcp4[0], exp_q[0] + 32'h4);
        tgt = exp_q.pop_front();
        exp_q.push_back(tgt + 32'h4);
        consumed++;
      end
      if (r) begin
        exp_q.delete();
        exp_q.push_back({rpc[0][31:2], 2'b00});
      end
    end
    stall[0] = 1'b0; redirect[0] = 1'b0;
    chk("rand_progress", 32'(consumed >= 200), 32'h1);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
